ppa_pipe: RTL and testbench

- Parametrised, pipelined Sklansky parallel-prefix adder/subtractor.
- Successor to the fixed 16-bit combinational prefix adder. Generalises width, adds carry-in, subtract mode, signed overflow, and configurable pipeline-register insertion between prefix levels.
- Valid-tagged stream with a global stall enable.
- Sits in datapaths that need sustained one-result-per-cycle throughput at frequencies the flat prefix tree cannot close.

---
 rtl/ppa_pipe_if.sv | 38 +++
 rtl/ppa_pipe.sv | 161 ++++++++++++++++
 tb/tb_ppa_pipe.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ppa_pipe_if.sv
// ----------------------------------------------------------------------------
// ppa_pipe_if
// Stream bundle for the pipelined prefix adder/subtractor.
//   EN   pipeline advance (0 freezes every stage)
//   VI   input valid
//   A/B  operands, WIDTH bits
//   CI   carry-in (ignored for subtract)
//   SUB  1: A-B
//   VO   result valid
//   S    sum/difference, WIDTH bits
//   CO   carry-out (subtract: 1 = no borrow)
//   OV   signed two's-complement overflow
// master drives operands and sees results; slave is the adder itself.
// ----------------------------------------------------------------------------
interface ppa_pipe_if #(
   parameter int WIDTH = 16
) ();
   logic             EN;
   logic             VI;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             CI;
   logic             SUB;
   logic             VO;
   logic [WIDTH-1:0] S;
   logic             CO;
   logic             OV;

   modport master (
      output EN, VI, A, B, CI, SUB,
      input  VO, S, CO, OV
   );

   modport slave (
      input  EN, VI, A, B, CI, SUB,
      output VO, S, CO, OV
   );
endinterface

// File: rtl/ppa_pipe.sv
// ----------------------------------------------------------------------------
// ppa_pipe
// Parametrised, pipelined Sklansky parallel-prefix adder/subtractor.
//   CLK  rising-edge clock
//   RST  synchronous active-high reset; clears all valid bits and the
//        output register, regardless of EN
//   bus  ppa_pipe_if slave: EN/VI/A/B/CI/SUB in, VO/S/CO/OV out
// Parameters:
//   WIDTH      operand width (>= 2); prefix depth L = clog2(WIDTH)
//   REG_EVERY  prefix levels per pipeline stage (1..L)
// Latency from an accepted VI to VO is 1 + ceil(L/REG_EVERY) cycles:
// one operand-prep register, a bank after every REG_EVERY prefix levels,
// and the output register after the last level.
// ----------------------------------------------------------------------------
module ppa_pipe #(
   parameter int WIDTH     = 16,
   parameter int REG_EVERY = 1
) (
   input  logic       CLK,
   input  logic       RST,
   ppa_pipe_if.slave  bus
);

   localparam int L = $clog2(WIDTH);

   // ------------------------------------------------------------------
   // Operand prep: subtract becomes A + ~B + 1; the carry-in is folded
   // into bit 0's generate so the tree yields carries including it.
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] be;
   logic [WIDTH-1:0] p_pre;
   logic [WIDTH-1:0] g_pre;
   logic [WIDTH-1:0] x_pre;
   logic             ce_pre;

   always_comb begin
      be       = bus.SUB ? ~bus.B : bus.B;
      ce_pre   = bus.SUB | bus.CI;
      p_pre    = bus.A | be;
      g_pre    = bus.A & be;
      x_pre    = bus.A ^ be;
      g_pre[0] = g_pre[0] | (p_pre[0] & ce_pre);
   end

   logic [WIDTH-1:0] p_s1;
   logic [WIDTH-1:0] g_s1;
   logic [WIDTH-1:0] x_s1;
   logic             ce_s1;
   logic             v_s1;

   // Data registers only need to follow EN; a stale payload behind a
   // cleared valid bit is never observed.
   always_ff @(posedge CLK) begin
      if (RST) begin
         v_s1 <= 1'b0;
      end else if (bus.EN) begin
         v_s1  <= bus.VI;
         p_s1  <= p_pre;
         g_s1  <= g_pre;
         x_s1  <= x_pre;
         ce_s1 <= ce_pre;
      end
   end

   // ------------------------------------------------------------------
   // Prefix tree. lvl[k] holds the inputs to level k (either wired from
   // the previous level or a register bank) and its combined outputs.
   // At level k, bit i with bit k set merges with the bit that has i's
   // upper bits, bit k cleared and the low k bits set, so after level k
   // bit i covers the group down to i with its low k+1 bits cleared.
   // ------------------------------------------------------------------
   for (genvar k = 0; k < L; k++) begin : lvl
      logic [WIDTH-1:0] g_i;
      logic [WIDTH-1:0] p_i;
      logic [WIDTH-1:0] x_i;
      logic             ce_i;
      logic             v_i;
      logic [WIDTH-1:0] g_o;
      logic [WIDTH-1:0] p_o;

      if (k == 0) begin : src_s1
         assign g_i  = g_s1;
         assign p_i  = p_s1;
         assign x_i  = x_s1;
         assign ce_i = ce_s1;
         assign v_i  = v_s1;
      end else if ((k % REG_EVERY) == 0) begin : src_bank
         always_ff @(posedge CLK) begin
            if (RST) begin
               v_i <= 1'b0;
            end else if (bus.EN) begin
               v_i  <= lvl[k-1].v_i;
               g_i  <= lvl[k-1].g_o;
               p_i  <= lvl[k-1].p_o;
               x_i  <= lvl[k-1].x_i;
               ce_i <= lvl[k-1].ce_i;
            end
         end
      end else begin : src_wire
         assign g_i  = lvl[k-1].g_o;
         assign p_i  = lvl[k-1].p_o;
         assign x_i  = lvl[k-1].x_i;
         assign ce_i = lvl[k-1].ce_i;
         assign v_i  = lvl[k-1].v_i;
      end

      for (genvar i = 0; i < WIDTH; i++) begin : node
         if (((i >> k) & 1) == 1) begin : merge
            localparam int J = ((i >> (k + 1)) << (k + 1)) | ((1 << k) - 1);
            assign g_o[i] = g_i[i] | (p_i[i] & g_i[J]);
            assign p_o[i] = p_i[i] & p_i[J];
         end else begin : pass
            assign g_o[i] = g_i[i];
            assign p_o[i] = p_i[i];
         end
      end
   end

   // ------------------------------------------------------------------
   // Sum, carry-out and overflow from the final carries c[i] = G[i:0].
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] c;
   logic [WIDTH-1:0] x_f;
   logic             ce_f;
   logic             v_f;
   logic [WIDTH-1:0] s_nxt;
   logic             unused_p;

   assign c        = lvl[L-1].g_o;
   assign x_f      = lvl[L-1].x_i;
   assign ce_f     = lvl[L-1].ce_i;
   assign v_f      = lvl[L-1].v_i;
   // Group propagate of the final level has no consumer.
   assign unused_p = ^lvl[L-1].p_o;
   assign s_nxt    = x_f ^ {c[WIDTH-2:0], ce_f};

   logic             vo_q;
   logic [WIDTH-1:0] s_q;
   logic             co_q;
   logic             ov_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         vo_q <= 1'b0;
         s_q  <= '0;
         co_q <= 1'b0;
         ov_q <= 1'b0;
      end else if (bus.EN) begin
         vo_q <= v_f;
         s_q  <= s_nxt;
         co_q <= c[WIDTH-1];
         ov_q <= c[WIDTH-1] ^ c[WIDTH-2];
      end
   end

   assign bus.VO = vo_q;
   assign bus.S  = s_q;
   assign bus.CO = co_q;
   assign bus.OV = ov_q;

endmodule

// File: tb/tb_ppa_pipe.sv
// ----------------------------------------------------------------------------
// tb_ppa_pipe
// Bench for ppa_pipe. The main instance (WIDTH=16, REG_EVERY=1) is tracked
// by a cycle-level behavioural model (integer arithmetic feeding a delay
// line of LATENCY slots that advances on EN and clears on RST) and checked
// every cycle. Directed tests pin latency, literal results, stall and
// reset behaviour; a set of extra instances covers other WIDTH/REG_EVERY
// combinations with the all-ones + 0 + carry-in case.
// ----------------------------------------------------------------------------
module tb_ppa_pipe;

   localparam int LAT = 5;
   localparam int NSW = 10;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   ppa_pipe_if #(.WIDTH(16)) bus ();

   ppa_pipe #(.WIDTH(16), .REG_EVERY(1)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.slave)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Reference result: {co, ov, s} from plain integer arithmetic.
   function automatic logic [17:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                          input logic ci, input logic sub);
      int  ua, ub, sa, sb, sum, ssum;
      logic co, ov;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sub) begin
         sum  = ua - ub;
         co   = (ua >= ub);
         ssum = sa - sb;
      end else begin
         sum  = ua + ub + int'(ci);
         co   = (sum > 65535);
         ssum = sa + sb + int'(ci);
      end
      ov = (ssum > 32767) || (ssum < -32768);
      return {co, ov, sum[15:0]};
   endfunction

   // ------------------------------------------------------------------
   // Behavioural model: slot 0 receives the accepted operation, slot
   // LAT-1 is what the outputs must show. k = payload is defined.
   // ------------------------------------------------------------------
   logic        m_v  [LAT];
   logic        m_k  [LAT];
   logic [15:0] m_s  [LAT];
   logic        m_co [LAT];
   logic        m_ov [LAT];
   logic [17:0] r_now;

   assign r_now = ref_op(bus.A, bus.B, bus.CI, bus.SUB);

   always @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < LAT; i++) begin
            m_v[i] <= 1'b0;
            m_k[i] <= 1'b0;
         end
         m_k[LAT-1]  <= 1'b1;
         m_s[LAT-1]  <= 16'h0000;
         m_co[LAT-1] <= 1'b0;
         m_ov[LAT-1] <= 1'b0;
      end else if (bus.EN) begin
         for (int i = 1; i < LAT; i++) begin
            m_v[i]  <= m_v[i-1];
            m_k[i]  <= m_k[i-1];
            m_s[i]  <= m_s[i-1];
            m_co[i] <= m_co[i-1];
            m_ov[i] <= m_ov[i-1];
         end
         m_v[0]  <= bus.VI;
         m_k[0]  <= bus.VI;
         m_s[0]  <= r_now[15:0];
         m_co[0] <= r_now[17];
         m_ov[0] <= r_now[16];
      end
   end

   logic chk_on = 1'b0;
   int   vo_cnt = 0;
   int   vo_run = 0;
   int   vo_max = 0;

   initial forever begin
      @(negedge CLK);
      if (chk_on) begin
         check("model_vo", 64'(bus.VO), 64'(m_v[LAT-1]));
         if (m_k[LAT-1]) begin
            check("model_s",  64'(bus.S),  64'(m_s[LAT-1]));
            check("model_co", 64'(bus.CO), 64'(m_co[LAT-1]));
            check("model_ov", 64'(bus.OV), 64'(m_ov[LAT-1]));
         end
         if (bus.VO) begin
            vo_cnt++;
            vo_run++;
            if (vo_run > vo_max) vo_max = vo_run;
         end else begin
            vo_run = 0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Parameter sweep instances
   // ------------------------------------------------------------------
   function automatic int sw_w(input int i);
      case (i)
         0, 1:    return 8;
         2, 3:    return 13;
         4, 5:    return 32;
         6, 7:    return 64;
         default: return 16;
      endcase
   endfunction

   function automatic int sw_r(input int i);
      case (i)
         0: return 1;  1: return 3;
         2: return 1;  3: return 4;
         4: return 1;  5: return 5;
         6: return 1;  7: return 6;
         8: return 2;  default: return 4;
      endcase
   endfunction

   logic sw_vi = 1'b0;
   int   sw_seen [NSW];
   logic sw_szero[NSW];
   logic sw_co   [NSW];
   logic sw_ov   [NSW];

   for (genvar gi = 0; gi < NSW; gi++) begin : sw
      localparam int W = sw_w(gi);
      localparam int R = sw_r(gi);

      ppa_pipe_if #(.WIDTH(W)) sbus ();

      ppa_pipe #(.WIDTH(W), .REG_EVERY(R)) u_dut (
         .CLK (CLK),
         .RST (RST),
         .bus (sbus.slave)
      );

      assign sbus.EN  = bus.EN;
      assign sbus.VI  = sw_vi;
      assign sbus.A   = '1;
      assign sbus.B   = '0;
      assign sbus.CI  = 1'b1;
      assign sbus.SUB = 1'b0;

      int   seen_cyc = -1;
      logic s_zero   = 1'b0;
      logic co_v     = 1'b0;
      logic ov_v     = 1'b0;

      initial forever begin
         @(negedge CLK);
         if (seen_cyc < 0 && sbus.VO) begin
            seen_cyc = cyc;
            s_zero   = (sbus.S == '0);
            co_v     = sbus.CO;
            ov_v     = sbus.OV;
         end
      end

      assign sw_seen[gi]  = seen_cyc;
      assign sw_szero[gi] = s_zero;
      assign sw_co[gi]    = co_v;
      assign sw_ov[gi]    = ov_v;
   end

   // ------------------------------------------------------------------
   // Stimulus helpers (all called at a falling edge)
   // ------------------------------------------------------------------
   task automatic step();
      @(negedge CLK);
   endtask

   task automatic drive(input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic sub, input logic vi);
      bus.A   = a;
      bus.B   = b;
      bus.CI  = ci;
      bus.SUB = sub;
      bus.VI  = vi;
   endtask

   task automatic drive_rand();
      drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
   endtask

   task automatic wait_vo(input int c0, output int lat);
      lat = -1;
      for (int n = 0; n < 40; n++) begin
         if (bus.VO) begin
            lat = cyc - c0;
            break;
         end
         step();
      end
   endtask

   task automatic single(input string t, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic sub,
                         input logic [15:0] es, input logic eco, input logic eov);
      int c0, lat;
      c0 = cyc;
      drive(a, b, ci, sub, 1'b1);
      step();
      bus.VI = 1'b0;
      wait_vo(c0, lat);
      check({t, "_lat"}, 64'(lat), 64'(LAT));
      check({t, "_s"},   64'(bus.S),  64'(es));
      check({t, "_co"},  64'(bus.CO), 64'(eco));
      check({t, "_ov"},  64'(bus.OV), 64'(eov));
      step();
      check({t, "_vo_after"}, 64'(bus.VO), 64'd0);
   endtask

   initial begin
      int c0, lat, base;

      RST    = 1'b1;
      bus.EN = 1'b0;
      drive(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
      repeat (3) step();

      // Reset state (reset applied with EN=0)
      check("rst_vo", 64'(bus.VO), 64'd0);
      check("rst_s",  64'(bus.S),  64'd0);
      check("rst_co", 64'(bus.CO), 64'd0);
      check("rst_ov", 64'(bus.OV), 64'd0);
      RST    = 1'b0;
      bus.EN = 1'b1;
      chk_on = 1'b1;
      repeat (2) step();

      // Wrap-around add, then subtract cases
      single("t1_wrap",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      single("t2_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      single("t2_ovf",    16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      single("t2_addov",  16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);

      // Back-to-back stream
      step();
      base   = vo_cnt;
      vo_max = 0;
      for (int n = 0; n < 100; n++) begin
         drive_rand();
         step();
      end
      bus.VI = 1'b0;
      repeat (LAT + 3) step();
      check("t3_count", 64'(vo_cnt - base), 64'd100);
      check("t3_run",   64'(vo_max),        64'd100);

      // Stall mid-flight
      c0 = cyc;
      for (int n = 0; n < 3; n++) begin
         drive_rand();
         step();
      end
      bus.VI = 1'b0;
      bus.EN = 1'b0;
      repeat (4) step();
      bus.EN = 1'b1;
      wait_vo(c0, lat);
      check("t4_lat", 64'(lat), 64'(LAT + 4));
      repeat (LAT + 3) step();

      // Reset mid-flight, with an operation offered in the reset cycle
      for (int n = 0; n < 3; n++) begin
         drive_rand();
         step();
      end
      drive(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
      RST = 1'b1;
      step();
      RST    = 1'b0;
      bus.VI = 1'b0;
      check("t5_vo", 64'(bus.VO), 64'd0);
      check("t5_s",  64'(bus.S),  64'd0);
      check("t5_co", 64'(bus.CO), 64'd0);
      check("t5_ov", 64'(bus.OV), 64'd0);
      base = vo_cnt;
      repeat (LAT + 3) step();
      check("t5_no_stale", 64'(vo_cnt - base), 64'd0);
      single("t5_new", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);

      // Parameter sweep: all-ones + 0 + carry-in on every extra instance
      step();
      c0    = cyc;
      sw_vi = 1'b1;
      step();
      sw_vi = 1'b0;
      repeat (12) step();
      for (int i = 0; i < NSW; i++) begin
         int w, r, lexp;
         w    = sw_w(i);
         r    = sw_r(i);
         lexp = 1 + ($clog2(w) + r - 1) / r;
         check($sformatf("t6_w%0d_r%0d_lat", w, r), 64'(sw_seen[i] - c0), 64'(lexp));
         check($sformatf("t6_w%0d_r%0d_s0", w, r),  64'(sw_szero[i]), 64'd1);
         check($sformatf("t6_w%0d_r%0d_co", w, r),  64'(sw_co[i]),    64'd1);
         check($sformatf("t6_w%0d_r%0d_ov", w, r),  64'(sw_ov[i]),    64'd0);
      end

      chk_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
